// File: rtl/hazard_controller_pkg.sv
// Shared pipeline-control types: hazard FSM states and ALU operand forward-select codes.
// Imported by the hazard controller and its forwarding sub-module.
package ControlTypeDefs;

    typedef enum logic [1:0] {
        RUN             = 2'd0,
        MEM_WAIT        = 2'd1,
        TIMEOUT_RECOVER = 2'd2
    } HazardState;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline register addresses/enables in, stage stall/flush/forward controls out.
// Purely combinational bundle; the controller only observes and never backpressures its inputs.
interface hazard_controller_if #(
    parameter int STALL_CNT_W = 16
);
    logic [4:0]             iRs1D;
    logic [4:0]             iRs2D;
    logic [4:0]             iRs1E;
    logic [4:0]             iRs2E;
    logic [4:0]             iRdE;
    logic                   iResultSrcE;
    logic [4:0]             iRdM;
    logic                   iRegWriteM;
    logic [4:0]             iRdW;
    logic                   iRegWriteW;
    logic                   iPCSrcE;
    logic                   iMemReq;
    logic                   iMemAck;
    logic                   oStallF;
    logic                   oStallD;
    logic                   oStallE;
    logic                   oStallM;
    logic                   oFlushD;
    logic                   oFlushE;
    logic [1:0]             oForwardAE;
    logic [1:0]             oForwardBE;
    logic                   oMemTimeout;
    logic [STALL_CNT_W-1:0] oStallCycles;

    modport master (
        output iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iResultSrcE,
               iRdM, iRegWriteM, iRdW, iRegWriteW, iPCSrcE, iMemReq, iMemAck,
        input  oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE,
               oForwardAE, oForwardBE, oMemTimeout, oStallCycles
    );

    modport slave (
        input  iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iResultSrcE,
               iRdM, iRegWriteM, iRdW, iRegWriteW, iPCSrcE, iMemReq, iMemAck,
        output oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE,
               oForwardAE, oForwardBE, oMemTimeout, oStallCycles
    );

endinterface

// File: rtl/hazard_controller_forward_select.sv
// ALU operand bypass select for one execute-stage source register; memory stage wins over writeback.
// Zero latency, pure combinational; x0 is never bypassed since it always reads as zero.
module forward_select
    import ControlTypeDefs::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic       wr_mem,
    input  logic [4:0] rd_wb,
    input  logic       wr_wb,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_REG;
        if (wr_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
            sel = FWD_MEM;
        end else if (wr_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: forwarding, load-use stall, data-memory wait with timeout, branch flush.
// Controls are combinational in the current cycle; a memory stall freezes F/D/E/M and defers branch flushes.
module hazard_controller
    import ControlTypeDefs::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int STALL_CNT_W    = 16
) (
    input  logic             iClk,
    input  logic             iRstN,
    hazard_controller_if.slave hz
);

    localparam int                WAIT_W    = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    HazardState             state;
    HazardState             state_nxt;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [WAIT_W-1:0]      wait_cnt_nxt;
    logic                   pend_flush;
    logic                   pend_flush_nxt;
    logic                   timeout_q;
    logic                   timeout_nxt;
    logic [STALL_CNT_W-1:0] stall_cnt;

    logic                   mem_stall;
    logic                   load_use;
    logic                   flush;
    logic                   stall_fd;
    logic                   flush_e;
    fwd_sel_t               fwd_a;
    fwd_sel_t               fwd_b;

    forward_select u_fwd_a (
        .rs     (hz.iRs1E),
        .rd_mem (hz.iRdM),
        .wr_mem (hz.iRegWriteM),
        .rd_wb  (hz.iRdW),
        .wr_wb  (hz.iRegWriteW),
        .sel    (fwd_a)
    );

    forward_select u_fwd_b (
        .rs     (hz.iRs2E),
        .rd_mem (hz.iRdM),
        .wr_mem (hz.iRegWriteM),
        .rd_wb  (hz.iRdW),
        .wr_wb  (hz.iRegWriteW),
        .sel    (fwd_b)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state      <= RUN;
            wait_cnt   <= '0;
            pend_flush <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            pend_flush <= pend_flush_nxt;
            timeout_q  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        pend_flush_nxt = pend_flush;
        timeout_nxt    = timeout_q;
        mem_stall      = 1'b0;
        flush          = 1'b0;

        load_use = (state == RUN) && hz.iResultSrcE && (hz.iRdE != 5'd0) &&
                   ((hz.iRdE == hz.iRs1D) || (hz.iRdE == hz.iRs2D));

        case (state)
            RUN: begin
                if (hz.iMemReq && !hz.iMemAck) begin
                    mem_stall    = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            MEM_WAIT: begin
                // The ack cycle itself is released so the completing access advances.
                if (hz.iMemAck) begin
                    state_nxt      = RUN;
                    flush          = pend_flush;
                    pend_flush_nxt = 1'b0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt   = TIMEOUT_RECOVER;
                        timeout_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            TIMEOUT_RECOVER: begin
                flush     = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // A redirect seen while frozen is remembered and replayed when the wait ends.
        if (hz.iPCSrcE) begin
            if (mem_stall) begin
                pend_flush_nxt = 1'b1;
            end else begin
                flush = 1'b1;
            end
        end

        // Recovery flushes unconditionally, so a remembered redirect is redundant.
        if (state_nxt == TIMEOUT_RECOVER) begin
            pend_flush_nxt = 1'b0;
        end

        stall_fd = mem_stall || (load_use && !flush);
        flush_e  = !mem_stall && (flush || load_use);
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            stall_cnt <= '0;
        end else if (stall_fd && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Combinational controls are held quiet while reset is asserted.
    assign hz.oStallF      = iRstN && stall_fd;
    assign hz.oStallD      = iRstN && stall_fd;
    assign hz.oStallE      = iRstN && mem_stall;
    assign hz.oStallM      = iRstN && mem_stall;
    assign hz.oFlushD      = iRstN && flush;
    assign hz.oFlushE      = iRstN && flush_e;
    assign hz.oForwardAE   = iRstN ? fwd_a : FWD_REG;
    assign hz.oForwardBE   = iRstN ? fwd_b : FWD_REG;
    assign hz.oMemTimeout  = timeout_q;
    assign hz.oStallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, memory wait, deferred flush,
// timeout recovery, reset behaviour and stall-counter saturation.
module tb_hazard_controller;
    import ControlTypeDefs::*;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    hazard_controller_if #(.STALL_CNT_W(16)) hz ();

    hazard_controller #(
        .TIMEOUT_CYCLES (256),
        .STALL_CNT_W    (16)
    ) dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.iRs1D = 5'd0; hz.iRs2D = 5'd0; hz.iRs1E = 5'd0; hz.iRs2E = 5'd0;
        hz.iRdE = 5'd0; hz.iResultSrcE = 1'b0;
        hz.iRdM = 5'd0; hz.iRegWriteM = 1'b0;
        hz.iRdW = 5'd0; hz.iRegWriteW = 1'b0;
        hz.iPCSrcE = 1'b0; hz.iMemReq = 1'b0; hz.iMemAck = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Order: {StallF, StallD, StallE, StallM, FlushD, FlushE}
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, hz.oStallF, hz.oStallD, hz.oStallE, hz.oStallM, hz.oFlushD, hz.oFlushE},
            {26'd0, exp});
    endtask

    // Asserts reset mid-cycle, checks its immediate effect, releases on the falling edge.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_ctl"}, {26'd0, hz.oStallF, hz.oStallD, hz.oStallE, hz.oStallM,
                            hz.oFlushD, hz.oFlushE}, 32'd0);
        chk({tag, "_timeout"}, hz.oMemTimeout, 32'd0);
        chk({tag, "_cycles"}, hz.oStallCycles, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        hz.iMemReq = 1'b1; hz.iRegWriteM = 1'b1; hz.iRdM = 5'd5; hz.iRs1E = 5'd5;
        hz.iResultSrcE = 1'b1; hz.iRdE = 5'd2; hz.iRs1D = 5'd2;
        cyc();
        @(negedge clk);
        chk_ctl("reset_ctl", 6'b000000);
        chk("reset_fwd_a", hz.oForwardAE, FWD_REG);
        chk("reset_cycles", hz.oStallCycles, 32'd0);
        chk("reset_timeout", hz.oMemTimeout, 32'd0);
        idle();
        rst_n = 1'b1;
        cyc();

        // Forwarding
        hz.iRegWriteM = 1'b1; hz.iRdM = 5'd5; hz.iRegWriteW = 1'b1; hz.iRdW = 5'd5; hz.iRs1E = 5'd5;
        @(negedge clk);
        chk("fwd_a_mem", hz.oForwardAE, 32'h2);
        chk("fwd_b_none", hz.oForwardBE, 32'h0);
        cyc();
        hz.iRdM = 5'd0;
        @(negedge clk);
        chk("fwd_a_wb", hz.oForwardAE, 32'h1);
        cyc();
        hz.iRdM = 5'd5; hz.iRs1E = 5'd6; hz.iRs2E = 5'd5;
        @(negedge clk);
        chk("fwd_b_mem", hz.oForwardBE, 32'h2);
        chk("fwd_a_nomatch", hz.oForwardAE, 32'h0);
        cyc();
        hz.iRdM = 5'd0; hz.iRdW = 5'd0; hz.iRs1E = 5'd0; hz.iRs2E = 5'd0;
        @(negedge clk);
        chk("fwd_a_x0", hz.oForwardAE, 32'h0);
        chk("fwd_b_x0", hz.oForwardBE, 32'h0);
        cyc();
        hz.iRegWriteM = 1'b0; hz.iRegWriteW = 1'b0; hz.iRdM = 5'd9; hz.iRdW = 5'd9; hz.iRs1E = 5'd9;
        @(negedge clk);
        chk("fwd_a_nowrite", hz.oForwardAE, 32'h0);
        cyc();
        idle();

        // Load-use
        hz.iResultSrcE = 1'b1; hz.iRdE = 5'd7; hz.iRs2D = 5'd7;
        @(negedge clk);
        chk_ctl("lu_stall", 6'b110001);
        cyc();
        idle();
        @(negedge clk);
        chk_ctl("lu_one_cycle", 6'b000000);
        chk("lu_cycles", hz.oStallCycles, 32'd1);
        cyc();
        hz.iResultSrcE = 1'b1; hz.iRdE = 5'd0;
        @(negedge clk);
        chk_ctl("lu_x0", 6'b000000);
        cyc();
        hz.iRdE = 5'd7; hz.iRs1D = 5'd7; hz.iPCSrcE = 1'b1;
        @(negedge clk);
        chk_ctl("lu_vs_branch", 6'b000011);
        cyc();
        idle();
        @(negedge clk);
        chk("lu_branch_cycles", hz.oStallCycles, 32'd1);
        cyc();
        pulse_reset("rst1");

        // Memory wait, 3 stall cycles then ack; load-use in the first cycle is overridden
        hz.iMemReq = 1'b1; hz.iResultSrcE = 1'b1; hz.iRdE = 5'd7; hz.iRs1D = 5'd7;
        @(negedge clk);
        chk_ctl("mem_run_stall", 6'b111100);
        cyc();
        hz.iResultSrcE = 1'b0; hz.iRdE = 5'd0; hz.iRs1D = 5'd0;
        repeat (2) begin
            @(negedge clk);
            chk_ctl("mem_wait_stall", 6'b111100);
            cyc();
        end
        hz.iMemAck = 1'b1;
        @(negedge clk);
        chk_ctl("mem_ack", 6'b000000);
        chk("mem_cycles", hz.oStallCycles, 32'd3);
        cyc();
        idle();

        // Branch during memory wait is deferred to the ack cycle
        hz.iMemReq = 1'b1;
        @(negedge clk);
        chk_ctl("pend_a", 6'b111100);
        cyc();
        hz.iPCSrcE = 1'b1;
        @(negedge clk);
        chk_ctl("pend_pulse", 6'b111100);
        cyc();
        hz.iPCSrcE = 1'b0;
        @(negedge clk);
        chk_ctl("pend_hold", 6'b111100);
        cyc();
        hz.iMemAck = 1'b1;
        @(negedge clk);
        chk_ctl("pend_apply", 6'b000011);
        cyc();
        idle();
        @(negedge clk);
        chk_ctl("pend_once", 6'b000000);
        chk("pend_cycles", hz.oStallCycles, 32'd6);
        cyc();

        // Timeout: 1 RUN stall cycle + 256 MEM_WAIT cycles, then recovery flush
        hz.iMemReq = 1'b1;
        @(negedge clk);
        chk_ctl("to_start", 6'b111100);
        cyc();
        repeat (255) cyc();
        @(negedge clk);
        chk_ctl("to_last_wait", 6'b111100);
        chk("to_not_yet", hz.oMemTimeout, 32'd0);
        cyc();
        hz.iMemReq = 1'b0;
        @(negedge clk);
        chk_ctl("to_recover", 6'b000011);
        chk("to_flag", hz.oMemTimeout, 32'd1);
        chk("to_cycles", hz.oStallCycles, 32'd263);
        cyc();
        hz.iResultSrcE = 1'b1; hz.iRdE = 5'd4; hz.iRs2D = 5'd4;
        @(negedge clk);
        chk_ctl("to_back_run", 6'b110001);
        chk("to_sticky", hz.oMemTimeout, 32'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("to_sticky2", hz.oMemTimeout, 32'd1);
        chk("to_cycles2", hz.oStallCycles, 32'd264);
        cyc();
        pulse_reset("rst_to");

        // Reset during MEM_WAIT drops the remembered branch
        hz.iMemReq = 1'b1;
        @(negedge clk);
        chk_ctl("rw_first_edge", 6'b111100);
        cyc();
        hz.iPCSrcE = 1'b1;
        @(negedge clk);
        chk_ctl("rw_pend", 6'b111100);
        cyc();
        pulse_reset("rst_wait");
        hz.iMemReq = 1'b1;
        @(negedge clk);
        chk_ctl("rw_restart", 6'b111100);
        cyc();
        hz.iMemAck = 1'b1;
        @(negedge clk);
        chk_ctl("rw_no_stale_flush", 6'b000000);
        cyc();
        idle();
        pulse_reset("rst_sat");

        // Stall counter saturation
        hz.iResultSrcE = 1'b1; hz.iRdE = 5'd3; hz.iRs1D = 5'd3;
        repeat (65534) cyc();
        @(negedge clk);
        chk("sat_below", hz.oStallCycles, 32'h0000FFFE);
        cyc();
        @(negedge clk);
        chk("sat_reach", hz.oStallCycles, 32'h0000FFFF);
        repeat (3) cyc();
        @(negedge clk);
        chk("sat_hold", hz.oStallCycles, 32'h0000FFFF);
        chk_ctl("sat_still_stalling", 6'b110001);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
